// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the RV32I core and its data memory.
// Latency: none, wires only.
// Backpressure: req_ready from the responder; responses are never backpressured.
// Signals:
//   req_valid/req_ready     request handshake (req_valid is the core's mem_enable)
//   req_we                  0 = load, 1 = store
//   req_func                RV32I funct3 size/sign code
//   req_addr/req_wdata      byte address and lane-0 aligned store data
//   rsp_valid               one-cycle response pulse
//   rsp_rdata/rsp_err       extended load data and access fault, qualified by rsp_valid
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side
  modport master (
    output req_valid, req_we, req_func, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side
  modport slave (
    input  req_valid, req_we, req_func, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory target for the RV32I load/store path: byte-lane stores, sign/zero-extended loads.
// Latency: accept at edge N -> rsp_valid in cycle N+1+WAIT_STATES; one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready high only in IDLE; rsp_valid is a pulse the core must take, no response stall.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          data_mem_responder_if.slave (request handshake in, response pulse out)
// Parameters: DEPTH_WORDS (32-bit words in the array), WAIT_STATES (0..15 extra cycles before response).
// Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses;
// when undefined the offending low address bits are cleared and the access proceeds.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT is entered with this value and left when the counter reaches zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  wait_cnt;
  logic        cap_we;
  logic [2:0]  cap_func;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;

  // Access operands: live inputs on the accept cycle (needed when WAIT_STATES=0),
  // the captured request otherwise.
  logic        a_we;
  logic [2:0]  a_func;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic             in_range;
  logic [IDX_W-1:0] mem_idx;
  logic             func_ok;
  logic             is_half;
  logic             is_word;
  logic [1:0]       lane;
  logic             fault;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_val;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data;
  logic             do_write;

  assign accept = (state == S_IDLE) && bus.req_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- capture and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_func  <= 3'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      wait_cnt  <= 4'd0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_func  <= bus.req_func;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    if (state == S_IDLE) begin
      a_we    = bus.req_we;
      a_func  = bus.req_func;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
    end else begin
      a_we    = cap_we;
      a_func  = cap_func;
      a_addr  = cap_addr;
      a_wdata = cap_wdata;
    end
  end

  // ------------------------------------------------------------- decode
  always_comb begin
    in_range = ({2'b00, a_addr[31:2]} < 32'(DEPTH_WORDS));
    mem_idx  = a_addr[IDX_W+1:2];
    is_half  = (a_func[1:0] == 2'b01);
    is_word  = (a_func[1:0] == 2'b10);
    // Stores have no unsigned forms; loads reject 011, 110 and 111.
    if (a_we) begin
      func_ok = !a_func[2] && (a_func[1:0] != 2'b11);
    end else begin
      func_ok = (a_func[1:0] != 2'b11) && (a_func != 3'b110);
    end
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    lane  = a_addr[1:0];
    fault = !func_ok || !in_range ||
            (is_half && a_addr[0]) || (is_word && (a_addr[1:0] != 2'b00));
`else
    // Misaligned halves/words silently drop the offending low address bits.
    if (is_word) begin
      lane = 2'b00;
    end else if (is_half) begin
      lane = {a_addr[1], 1'b0};
    end else begin
      lane = a_addr[1:0];
    end
    fault = !func_ok || !in_range;
`endif
  end

  // --------------------------------------------------------------- load
  always_comb begin
    rd_word = mem_q[mem_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (a_func)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  // -------------------------------------------------------------- store
  always_comb begin
    case (a_func[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << lane;
        wr_data = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wr_mask = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = a_wdata;
      end
    endcase
  end

  // The write lands on the edge entering RESP; a reset mid-request returns
  // the FSM to IDLE first, so a pending store never reaches the array.
  assign do_write = enter_resp && a_we && !fault && rst_n;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem_q[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------- response
  // Data and error are registered once per request and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (a_we || fault) ? 32'd0 : load_val;
      rsp_err   <= fault;
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

endmodule
